prach_hb_split: RTL
===================

# prach_hb_split

Polyphase splitter that sits directly upstream of the PRACH halfband decimator (hb5). It receives one full-rate TDM sample stream with one 256-slot frame per sample period and 48 active channels. It stores each channel's even-phase sample and, on the following odd frame, emits the (odd, even) pair on the two polyphase lanes the decimator consumes. Output frames alternate between data frames and idle frames, which halves the per-channel sample rate seen downstream.

## Interface
Parameters:
- `NUM_CHN_USED`, 48: active channels, slots 0..NUM_CHN_USED-1; other slots are don't-care input.
- `LATENCY`, 2: input-to-output latency in cycles; fixed, not user-tunable.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `din_dq`  in  16  signed sample of slot `din_chn`.
- `din_chn`  in  8  TDM slot index; increments by 1 per cycle and wraps 255->0.
- `sync_in`  in  1  pulse marking slot 0 of an even frame.
- `dout_dp1`  out  16  odd-phase sample x[2n+1] (center-tap lane).
- `dout_dp2`  out  16  even-phase sample x[2n] (symmetric-tap lane).
- `dout_chn`  out  8  output slot index; 8'hFF in idle frames.
- `sync_out`  out  1  pulse with slot 0 of the first data frame after a sync.
- `err`  out  1  sticky slot/sync error flag (see Configuration).

## Operation
- Frame phase register `ph` (0 = even, 1 = odd) toggles when an input slot with `din_chn==255` is accepted.
- `sync_in` with `din_chn==0`:
  - If `ph` is already even: no change.
  - If `ph` is odd: force `ph=0` and clear `primed`.
- `sync_in` with `din_chn!=0` is ignored for phase purposes.
- `primed` is cleared by reset and by a realigning sync. It is set when slot 255 of an even frame is accepted.
- Even frame, `din_chn < NUM_CHN_USED`: write `din_dq` into a 48x16 RAM at address `din_chn`.
- Odd frame with `primed=1` and `din_chn < NUM_CHN_USED`:
  - Read the RAM at `din_chn`.
  - Output `dp1 = din_dq`, `dp2 = RAM word`, `dout_chn = din_chn`.
- All other slots: `dout_chn=8'hFF`, `dp1=dp2=0`. Downstream ignores slots >= 48, so its delay lines shift only on data slots.
- Unused data slots 48..255 inside a primed odd frame: `dout_chn` passes `din_chn` through and data is 0.
- `sync_out`: a `sync_in` at slot 0 arms a pending flag. The pending flag fires `sync_out` with output slot 0 of the next primed odd frame, then clears. A realigning sync re-arms the flag.
- No arithmetic is performed; samples pass bit-exact.

## Timing
- Slot accepted at cycle t appears on the outputs at t+2:
  - cycle 1: RAM read and input register.
  - cycle 2: output register.
- The RAM write in an even frame and the read of the same address in the next odd frame are at least 256 cycles apart. No read/write collision handling is needed.
- Reset values: `dout_dp1=0`, `dout_dp2=0`, `dout_chn=8'hFF`, `sync_out=0`, `err=0`. Internal reset values: `ph=0`, `primed=0`, pending sync flag = 0.
- Reset asserted mid-frame:
  - Outputs return to reset values on the next edge and the pipeline is flushed.
  - The first data frame is emitted only after one complete even frame has been captured.
- Simultaneous `sync_in` and `din_chn==255` cannot occur legally. If it does, sync takes priority and is flagged under `PRACH_SPLIT_CHK_EN`.

## Configuration
- `PRACH_SPLIT_CHK_EN` defined:
  - Expected-slot counter compares each `din_chn` against previous+1 (mod 256).
  - A mismatch, or `sync_in` at `din_chn!=0`, sets `err`, which stays set until `rst`.
  - A mismatch also clears `primed`, suppressing data until the next full even frame.
- `PRACH_SPLIT_CHK_EN` undefined: `err` is tied to 0 and there is no counter logic.

## Structure
- Shared package `prach_pkg` holds:
  - `NumChannel=256`
  - `NumChannelUsed=48`
  - `IdleChn=8'hFF`
  - typedef `sample_t` (logic signed [15:0])
  - typedef `chn_t` (logic [7:0])
- One sub-module, `prach_sdpram`: simple dual-port RAM, 48x16, registered read, `ramstyle "mlab"`. The top level holds the phase/primed/sync FSM, the output pipeline and the optional checker.

## Test plan
- Reset, then a continuous ramp where `din_dq = 256*frame + slot`, with `sync_in` at frame 0 slot 0.
  - Required: frame 0 outputs are all idle (`dout_chn=8'hFF`).
  - Required: frame 1 slot 5 appears at t+2 as `dp1=261`, `dp2=5`, `dout_chn=5`.
  - Required: `sync_out` is high exactly at frame 1 output slot 0.
- Steady state over 10 frame pairs.
  - Required: exactly 48 data slots per pair, with `dout_chn` values 0..47 in order.
  - Required: slots 48..255 carry `dp1=dp2=0`.
- `sync_in` at slot 0 of an odd frame (realignment).
  - Required: the current frame is treated as even and the next data frame is one frame later.
  - Required: `sync_out` fires on that data frame's slot 0.
- Assert `rst` for 3 cycles mid odd frame.
  - Required: outputs hold reset values on the next edge.
  - Required: no data is emitted until one full even frame has been captured.
- With `PRACH_SPLIT_CHK_EN`, skip slot 100 (99 is followed by 101).
  - Required: `err` rises and stays high.
  - Required: data is suppressed until after the next complete even frame.
- Signed extremes: even sample -32768 and odd sample 32767 on channel 47.
  - Required: `dp2=-32768`, `dp1=32767`, bit-exact.

Source files
------------

// File: rtl/prach_pkg.sv
// ============================================================================
//  prach_pkg
//  Shared constants and types for the PRACH polyphase splitter.
//  Rev 1.0
// ============================================================================
`default_nettype none

package prach_pkg;

    localparam int NumChannel     = 256;
    localparam int NumChannelUsed = 48;

    typedef logic signed [15:0] sample_t;
    typedef logic        [7:0]  chn_t;

    localparam chn_t IdleChn = 8'hFF;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

endpackage

`default_nettype wire

// File: rtl/prach_sdpram.sv
// ============================================================================
//  prach_sdpram
//  Simple dual-port RAM, one write port and one registered read port.
//  Rev 1.0
// ============================================================================
`default_nettype none

module prach_sdpram #(
    parameter int DEPTH  = 48,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    (* ramstyle = "mlab" *) logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/prach_hb_split.sv
// ============================================================================
//  prach_hb_split
//  Even/odd polyphase splitter feeding the PRACH halfband decimator.
//  Optional slot-sequence checker enabled by PRACH_SPLIT_CHK_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module prach_hb_split
    import prach_pkg::*;
#(
    parameter int NUM_CHN_USED = NumChannelUsed,
    parameter int LATENCY      = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t din_dq,
    input  chn_t    din_chn,
    input  logic    sync_in,
    output sample_t dout_dp1,
    output sample_t dout_dp2,
    output chn_t    dout_chn,
    output logic    sync_out,
    output logic    err
);

    localparam int c_ADDR_W = $clog2(NUM_CHN_USED);

    phase_e      r_ph;
    logic        r_primed;
    logic        r_clean;
    logic        r_pend;

    logic        w_sync0;
    logic        w_realign;
    phase_e      w_ph;
    logic        w_used;
    logic        w_last;
    logic        w_mismatch;
    logic        w_clean_now;
    logic        w_emit;
    logic        w_data;
    logic        w_sync_fire;
    logic [15:0] w_ram_q;

    // A slot-0 sync re-labels the slot it arrives with, not just the next one.
    assign w_sync0     = sync_in && (din_chn == '0);
    assign w_realign   = w_sync0 && (r_ph == PH_ODD);
    assign w_ph        = w_sync0 ? PH_EVEN : r_ph;
    assign w_used      = din_chn < chn_t'(NUM_CHN_USED);
    assign w_last      = din_chn == chn_t'(NumChannel - 1);
    assign w_clean_now = ((w_ph == PH_EVEN && din_chn == '0) || r_clean) && !w_mismatch;
    assign w_emit      = (w_ph == PH_ODD) && r_primed && !w_mismatch;
    assign w_data      = w_emit && w_used;
    assign w_sync_fire = r_pend && w_emit && (din_chn == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph     <= PH_EVEN;
            r_primed <= 1'b0;
            r_clean  <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            // Sync wins over the frame-end toggle if both ever coincide.
            if (w_sync0) begin
                r_ph <= PH_EVEN;
            end else if (w_last && !sync_in) begin
                r_ph <= (r_ph == PH_EVEN) ? PH_ODD : PH_EVEN;
            end

            if (w_realign || w_mismatch) begin
                r_primed <= 1'b0;
            end else if (w_ph == PH_EVEN && w_last && w_clean_now) begin
                r_primed <= 1'b1;
            end

            r_clean <= w_clean_now;

            if (w_sync0) begin
                r_pend <= 1'b1;
            end else if (w_sync_fire) begin
                r_pend <= 1'b0;
            end
        end
    end

`ifdef PRACH_SPLIT_CHK_EN
    chn_t r_prev;
    logic r_prev_vld;
    logic r_err;

    assign w_mismatch = r_prev_vld && (din_chn != chn_t'(r_prev + chn_t'(1)));
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_prev     <= din_chn;
            r_prev_vld <= 1'b1;
            if (w_mismatch || (sync_in && din_chn != '0)) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_mismatch = 1'b0;
    assign err        = 1'b0;
`endif

    prach_sdpram #(
        .DEPTH  (NUM_CHN_USED),
        .WIDTH  (16),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   ((w_ph == PH_EVEN) && w_used),
        .wr_addr (din_chn[c_ADDR_W-1:0]),
        .wr_data (din_dq),
        .rd_addr (din_chn[c_ADDR_W-1:0]),
        .rd_data (w_ram_q)
    );

    sample_t            r_dp1_pipe [LATENCY];
    chn_t               r_chn_pipe [LATENCY];
    sample_t            r_dp2_pipe [LATENCY-1];
    logic [LATENCY-1:0] r_sync_pipe;
    logic               r_rd_vld;

    // The RAM read register is the first stage of the even-phase lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_dp1_pipe[i] <= '0;
                r_chn_pipe[i] <= IdleChn;
            end
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_dp2_pipe[i] <= '0;
            end
            r_sync_pipe <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_dp1_pipe[0] <= w_data ? din_dq : '0;
            r_chn_pipe[0] <= w_emit ? din_chn : IdleChn;
            for (int i = 1; i < LATENCY; i++) begin
                r_dp1_pipe[i] <= r_dp1_pipe[i-1];
                r_chn_pipe[i] <= r_chn_pipe[i-1];
            end
            r_rd_vld      <= w_data;
            r_dp2_pipe[0] <= r_rd_vld ? sample_t'(w_ram_q) : '0;
            for (int i = 1; i < LATENCY - 1; i++) begin
                r_dp2_pipe[i] <= r_dp2_pipe[i-1];
            end
            r_sync_pipe <= {r_sync_pipe[LATENCY-2:0], w_sync_fire};
        end
    end

    assign dout_dp1 = r_dp1_pipe[LATENCY-1];
    assign dout_dp2 = r_dp2_pipe[LATENCY-2];
    assign dout_chn = r_chn_pipe[LATENCY-1];
    assign sync_out = r_sync_pipe[LATENCY-1];

endmodule

`default_nettype wire
